// File: rtl/vga_plot_framebuffer_pkg.sv
// vga_plot_framebuffer_pkg: shared VGA 640x480@60 timing constants, framebuffer size, colour bit indices, clear FSM states
package vga_pkg;
    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_SYNC_S = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_E = H_SYNC_S + H_SYNC;
    localparam logic [9:0] H_LAST   = H_SYNC_E + H_BP - 10'd1;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_SYNC_S = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_E = V_SYNC_S + V_SYNC;
    localparam logic [9:0] V_LAST   = V_SYNC_E + V_BP - 10'd1;
    localparam int FB_WORDS = 19200;
    localparam logic [14:0] FB_LAST = 15'(FB_WORDS - 1);
    localparam int COL_R = 2;
    localparam int COL_G = 1;
    localparam int COL_B = 0;
    typedef enum logic {IDLE, SWEEP} clr_state_e;
endpackage

// File: rtl/vga_plot_framebuffer_if.sv
// vga_plot_framebuffer_if: character plot bus; master = drawing controller, slave = framebuffer
//   vga_x, vga_y : plot coordinates   vga_color : {R,G,B}   vga_plot : write strobe
interface vga_plot_framebuffer_if;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_color;
    logic       vga_plot;
    modport master (output vga_x, vga_y, vga_color, vga_plot);
    modport slave  (input  vga_x, vga_y, vga_color, vga_plot);
endinterface

// File: rtl/vga_plot_framebuffer_frame_ram.sv
// frame_ram: 19200x3 simple dual-port RAM, write port A, registered read port B (old data on collision)
//   clk_i, we_i/waddr_i/wdata_i : write port   raddr_i -> rdata_o : 1-cycle read
module frame_ram
    import vga_pkg::*;
(
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [14:0] waddr_i,
    input  logic [2:0]  wdata_i,
    input  logic [14:0] raddr_i,
    output logic [2:0]  rdata_o
);
    logic [2:0] mem [FB_WORDS];
    logic [2:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_plot_framebuffer.sv
// vga_plot_framebuffer: 160x120x3 framebuffer with plot port, clear engine and 4x-scaled 640x480 VGA scan-out
//   clock_50, resetn : clock and async active-low reset
//   plot             : pixel write bus (slave)
//   clear, clear_color, busy : full-frame fill request, fill colour, sweep in progress
//   vga_r/g/b, vga_hs, vga_vs, vga_blank_n, vga_clk : VGA stream
module vga_plot_framebuffer
    import vga_pkg::*;
#(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int SCALE_LOG2 = 2
) (
    input  logic                    clock_50,
    input  logic                    resetn,
    vga_plot_framebuffer_if.slave   plot,
    input  logic                    clear,
    input  logic [2:0]              clear_color,
    output logic                    busy,
    output logic [7:0]              vga_r,
    output logic [7:0]              vga_g,
    output logic [7:0]              vga_b,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    vga_blank_n,
    output logic                    vga_clk
);
    logic        pix_en_q;
    logic [9:0]  h_q, v_q, h_d, v_d;
    clr_state_e  state_q;
    logic        busy_q;
    logic [14:0] sweep_addr_q;
    logic [2:0]  fill_q;
    logic        hs1_q, vs1_q, bl1_q;
    logic        hs_q, vs_q, bl_q;
    logic [2:0]  rgb_q;
    logic [14:0] rd_row, rd_addr, wr_row, wr_addr;
    logic [2:0]  wr_data, rd_data;
    logic        wr_en, plot_ok;

    always_comb begin
        h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
        v_d = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        // row*160 as row*128 + row*32
        rd_row  = 15'(v_q >> SCALE_LOG2);
        rd_addr = (rd_row << 7) + (rd_row << 5) + 15'(h_q >> SCALE_LOG2);
        wr_row  = 15'(plot.vga_y);
        plot_ok = plot.vga_plot && !busy_q && plot.vga_x < 8'(H_RES) && plot.vga_y < 8'(V_RES);
        wr_en   = busy_q || plot_ok;
        wr_addr = busy_q ? sweep_addr_q : (wr_row << 7) + (wr_row << 5) + 15'(plot.vga_x);
        wr_data = busy_q ? fill_q : plot.vga_color;
    end

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
        end else begin
            pix_en_q <= ~pix_en_q;
            if (pix_en_q) begin
                h_q <= h_d;
                v_q <= v_d;
            end
        end
    end

    // Reset lands in SWEEP so the frame is painted black before any plot is accepted.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= SWEEP;
            busy_q       <= 1'b1;
            sweep_addr_q <= '0;
            fill_q       <= '0;
        end else if (state_q == IDLE) begin
            if (clear) begin
                state_q      <= SWEEP;
                busy_q       <= 1'b1;
                sweep_addr_q <= '0;
                fill_q       <= clear_color;
            end
        end else begin
            sweep_addr_q <= sweep_addr_q + 15'd1;
            if (sweep_addr_q == FB_LAST) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

    frame_ram u_ram (
        .clk_i   (clock_50),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Stage 1 aligns syncs/blank with the RAM read; stage 2 registers the outputs.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            hs1_q <= 1'b1;
            vs1_q <= 1'b1;
            bl1_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            bl_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs1_q <= !(h_q >= H_SYNC_S && h_q < H_SYNC_E);
            vs1_q <= !(v_q >= V_SYNC_S && v_q < V_SYNC_E);
            bl1_q <= h_q < H_VIS && v_q < V_VIS;
            hs_q  <= hs1_q;
            vs_q  <= vs1_q;
            bl_q  <= bl1_q;
            rgb_q <= bl1_q ? rd_data : 3'b000;
        end
    end

    assign busy        = busy_q;
    assign vga_r       = {8{rgb_q[COL_R]}};
    assign vga_g       = {8{rgb_q[COL_G]}};
    assign vga_b       = {8{rgb_q[COL_B]}};
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = bl_q;
    assign vga_clk     = pix_en_q;
endmodule

// File: doc/vga_plot_framebuffer.md
# vga_plot_framebuffer

Receiving end of the character plot interface. It accepts one pixel write per clock (`vga_x`, `vga_y`, `vga_color`, `vga_plot`) from the sprite and maze drawing controllers and stores it in a 160x120, 3-bit framebuffer. It also scans the framebuffer out as a 640x480@60 Hz VGA stream, replicating each stored pixel 4x4. A clear engine fills the whole buffer with one colour after reset or on request.

## Interface
- `H_RES`, 160, stored frame width in pixels
- `V_RES`, 120, stored frame height in pixels
- `SCALE_LOG2`, 2, log2 of the replication factor from stored pixels to 640x480
- `clock_50` in 1: 50 MHz clock; the only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `vga_x` in 8: plot column, unsigned.
- `vga_y` in 8: plot row, unsigned.
- `vga_color` in 3: plot colour, {R,G,B}.
- `vga_plot` in 1: write strobe; one pixel per cycle where high.
- `clear` in 1: start a full-frame fill; sampled each cycle.
- `clear_color` in 3: fill colour; captured on an accepted `clear`.
- `busy` out 1: clear sweep in progress.
- `vga_r`, `vga_g`, `vga_b` out 8 each: each channel is its colour bit replicated 8 times.
- `vga_hs`, `vga_vs` out 1 each: active-low syncs.
- `vga_blank_n` out 1: high in the visible region.
- `vga_clk` out 1: 25 MHz pixel clock, equal to the registered pixel enable.

## Operation
- Pixel enable `pix_en`:
  - Toggles every `clock_50` cycle.
  - Reset value is 0.
  - The scan counters advance only in cycles where `pix_en` is 1.
- Horizontal counter `h`, range 0..799:
  - 0..639 visible, 640..655 front porch, 656..751 sync, 752..799 back porch.
  - Wraps 799 to 0 and increments `v`.
- Vertical counter `v`, range 0..524:
  - 0..479 visible, 480..489 front porch, 490..491 sync, 492..524 back porch.
  - Wraps 524 to 0.
- Scan read address: `(v>>2)*160 + (h>>2)`, 15 bits. Computed by shift-add (`*128 + *32`), no multiplier. Used only when visible; otherwise don't care.
- Plot write:
  - Accepted when `vga_plot`=1, `busy`=0, `vga_x`<160 and `vga_y`<120.
  - Address is `vga_y*160 + vga_x`; the write completes on that edge.
  - Out-of-range coordinates are silently dropped; there is no wrap.
- Clear FSM, states IDLE and SWEEP:
  - IDLE to SWEEP when `clear`=1. `clear_color` is latched and the sweep address is set to 0.
  - SWEEP writes the latched colour at the sweep address once per cycle, incrementing the address.
  - After writing address 19199 it returns to IDLE; `busy` falls on the following cycle.
  - `busy`=1 exactly in SWEEP.
  - `clear` asserted during SWEEP is ignored; it does not restart the sweep.
  - Plots during SWEEP are dropped.
- Reset:
  - Forces SWEEP with address 0 and colour 000, so the frame is defined black after reset. `busy` resets to 1.
  - Reset mid-sweep restarts the sweep from address 0.
- Write/read priority: the sweep write and the plot write are mutually exclusive, because plots are gated by `busy`. Scan reads use the second RAM port and never stall.
- Same-address read and write in the same cycle returns the old data.

## Timing
- Reset values:
  - `h`=0, `v`=0, `pix_en`=0.
  - `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0.
  - RGB=0.
  - `busy`=1, sweep address=0.
- Scan pipeline, 2 `clock_50` stages from a counter update to the outputs:
  - Stage 1: registered RAM read, plus registered hs/vs/blank derived from `h` and `v`.
  - Stage 2: output registers for RGB, hs, vs and `blank_n`.
- RGB is forced to 0 whenever the delayed `blank_n` is 0.
- Plot-to-visible latency: a plot on edge N is readable by any scan read issued on edge N+1 or later.
- Clear duration: exactly 19200 cycles with `busy`=1 from the accepting edge. After reset, `busy` falls 19200 cycles after `resetn` deasserts.
- One full frame is 800*525*2 = 840000 `clock_50` cycles.

## Structure
- Shared package `vga_pkg`, holding:
  - H/V visible, porch and sync constants.
  - `FB_WORDS`=19200.
  - Colour bit indices (R=2, G=1, B=0).
- Sub-module `frame_ram`:
  - Simple dual-port, 19200x3.
  - Write port A; registered read port B with 1-cycle latency.
  - Old-data behaviour on same-address read-during-write.
  - Inferable as M10K.
- The top level holds the timing counters, the clear FSM, the write-address arithmetic and the output pipeline.

## Test plan
- Reset, then wait for `busy`=0:
  - `busy` is high for exactly 19200 cycles.
  - The first visible frame is all RGB=0.
  - `vga_hs` low for 96 pixel periods per line; `vga_vs` low for 2 lines per frame.
- Plot (x=0, y=0, colour=100), then let the scan run: screen pixels (0..3, 0..3) show R=FF, G=00, B=00; all other pixels stay black.
- Plot (159, 119, 011): the bottom-right 4x4 block at screen (636..639, 476..479) shows R=00, G=FF, B=FF.
- Plots at (160, 0), (0, 120) and (255, 255): no RAM write, frame unchanged.
- `clear`=1 with `clear_color`=001, plus a plot at (5, 5, 100) during the sweep:
  - `busy` is high for 19200 cycles.
  - The full frame is blue afterwards.
  - The plot is dropped.
  - A second `clear` mid-sweep does not extend `busy`.
- Assert `resetn`=0 mid-sweep for 3 cycles:
  - All outputs are at their reset values while reset is asserted.
  - The sweep restarts at 0 with colour 000.
  - `busy` falls 19200 cycles after release.
